// File: rtl/tlb_cache.sv
// tlb_cache: fully-associative translation cache; lookup (pgnoin/memcycle -> hit/pfnout/flagsout), fill (tlbwr/writeentry), flush, inval, valid_cnt
module tlb_cache #(
  parameter int ENTRIES = 8,
  localparam int IDXW = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [51:0]     pgnoin,
  input  logic            memcycle,
  output logic            hit,
  output logic [51:0]     pfnout,
  output logic [11:0]     flagsout,
  input  logic            tlbwr,
  input  logic [63:0]     writeentry,
  input  logic            flush,
  input  logic            inval,
  output logic [IDXW:0]   valid_cnt
);
  logic [51:0] tag [ENTRIES];
  logic [63:0] data [ENTRIES];
  logic [ENTRIES-1:0] vld, m;
  logic [IDXW-1:0] ptr, m_idx, inv_idx, w_idx;
  logic [63:0] rd;
  logic any_m, any_inv, wr;
  always_comb begin
    m = '0;
    rd = '0;
    m_idx = '0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      m[i] = vld[i] && tag[i] == pgnoin;
      if (m[i]) begin
        m_idx = IDXW'(i);
        rd = data[i];
      end
      if (!vld[i]) inv_idx = IDXW'(i);
    end
  end
  assign any_m = |m;
  assign any_inv = ~&vld;
  assign hit = memcycle && any_m;
  assign pfnout = hit ? rd[63:12] : '0;
  assign flagsout = hit ? rd[11:0] : '0;
  assign w_idx = any_m ? m_idx : any_inv ? inv_idx : ptr;
  assign wr = tlbwr && writeentry[0] && !flush && !inval;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld <= '0;
      ptr <= '0;
      valid_cnt <= '0;
    end else if (flush) begin
      vld <= '0;
      ptr <= '0;
      valid_cnt <= '0;
    end else if (inval) begin
      if (any_m) begin
        vld[m_idx] <= 1'b0;
        valid_cnt <= valid_cnt - (IDXW+1)'(1);
      end
    end else if (wr) begin
      vld[w_idx] <= 1'b1;
      if (!any_m && !any_inv) ptr <= ptr + IDXW'(1);
      valid_cnt <= valid_cnt + (IDXW+1)'(!any_m && any_inv);
    end
  always_ff @(posedge clk)
    if (wr) begin
      tag[w_idx] <= pgnoin;
      data[w_idx] <= writeentry;
    end
endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: randomized and directed checks of tlb_cache against a slot-level reference model
module tb_tlb_cache;
  localparam int N = 8;
  logic clk = 0, reset_n = 0, memcycle = 0, tlbwr = 0, flush = 0, inval = 0;
  logic [51:0] pgnoin = '0;
  logic [63:0] writeentry = '0;
  logic hit;
  logic [51:0] pfnout;
  logic [11:0] flagsout;
  logic [3:0] valid_cnt;
  int n_chk = 0, n_fail = 0;
  logic [51:0] mt [N];
  logic [63:0] md [N];
  bit mv [N];
  int mp = 0;
  logic [51:0] pool [12];
  tlb_cache #(.ENTRIES(N)) dut (
    .clk(clk), .reset_n(reset_n), .pgnoin(pgnoin), .memcycle(memcycle), .hit(hit),
    .pfnout(pfnout), .flagsout(flagsout), .tlbwr(tlbwr), .writeentry(writeentry),
    .flush(flush), .inval(inval), .valid_cnt(valid_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int mfind(input logic [51:0] pg);
    for (int i = 0; i < N; i++) if (mv[i] && mt[i] == pg) return i;
    return -1;
  endfunction
  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return c;
  endfunction
  task automatic mreset();
    for (int i = 0; i < N; i++) mv[i] = 0;
    mp = 0;
  endtask
  task automatic mupdate(input logic [51:0] pg, input bit wr, input logic [63:0] we, input bit fl, input bit iv);
    int i;
    if (fl) mreset();
    else if (iv) begin
      i = mfind(pg);
      if (i >= 0) mv[i] = 0;
    end else if (wr && we[0]) begin
      i = mfind(pg);
      if (i < 0) for (int j = N - 1; j >= 0; j--) if (!mv[j]) i = j;
      if (i < 0) begin
        i = mp;
        mp = (mp + 1) % N;
      end
      mt[i] = pg;
      md[i] = we;
      mv[i] = 1;
    end
  endtask
  task automatic cyc(input bit mc, input logic [51:0] pg, input bit wr, input logic [63:0] we, input bit fl, input bit iv);
    int idx;
    bit e;
    memcycle = mc;
    pgnoin = pg;
    tlbwr = wr;
    writeentry = we;
    flush = fl;
    inval = iv;
    @(negedge clk);
    idx = mfind(pg);
    e = mc && idx >= 0;
    chk("hit", 64'(hit), 64'(e));
    chk("pfn", 64'(pfnout), e ? 64'(md[idx][63:12]) : 64'd0);
    chk("flags", 64'(flagsout), e ? 64'(md[idx][11:0]) : 64'd0);
    chk("cnt", 64'(valid_cnt), 64'(mcount()));
    @(posedge clk);
    mupdate(pg, wr, we, fl, iv);
    #1;
    tlbwr = 0;
    flush = 0;
    inval = 0;
  endtask
  task automatic look(input logic [51:0] pg);
    cyc(1, pg, 0, 64'd0, 0, 0);
  endtask
  initial begin
    logic [63:0] we;
    for (int k = 0; k < 12; k++) pool[k] = {20'($urandom), 32'($urandom)};
    pool[11] = pool[10] ^ 52'h8_0000_0000_0000;
    mreset();
    #12;
    chk("rst_cnt", 64'(valid_cnt), 64'd0);
    reset_n = 1;
    @(posedge clk);
    #1;
    look(52'h12345);
    cyc(1, 52'h12345, 1, 64'hABCD_E000_0000_1003, 0, 0);
    #1;
    chk("t2_hit", 64'(hit), 64'd1);
    chk("t2_pfn", 64'(pfnout), 64'hABCDE_0000_0001);
    chk("t2_flags", 64'(flagsout), 64'h003);
    chk("t2_cnt", 64'(valid_cnt), 64'd1);
    look(52'h12345);
    cyc(1, 52'h777, 1, 64'h5555_0000_0000_1002, 0, 0);
    look(52'h777);
    cyc(0, 52'h0, 0, 64'd0, 1, 0);
    for (int k = 1; k <= 9; k++) cyc(1, 52'(100 + k), 1, {32'($urandom), 32'($urandom) | 32'd1}, 0, 0);
    #1;
    chk("t4_cnt", 64'(valid_cnt), 64'd8);
    look(52'd101);
    look(52'd109);
    cyc(1, 52'd105, 1, 64'hFEDC_BA98_7654_3211, 0, 0);
    cyc(1, 52'd110, 1, 64'h1111_2222_3333_4441, 0, 0);
    look(52'd102);
    look(52'd105);
    look(52'd110);
    cyc(1, 52'd200, 1, 64'h9999_0000_0000_0001, 1, 0);
    look(52'd200);
    look(52'd105);
    for (int k = 1; k <= 3; k++) cyc(0, 52'(300 + k), 1, 64'(k * 4096 + 1), 0, 0);
    cyc(1, 52'd302, 1, 64'hAAAA_0000_0000_0001, 0, 1);
    look(52'd302);
    look(52'd301);
    look(52'd303);
    cyc(0, 52'd999, 0, 64'd0, 0, 1);
    look(52'd303);
    for (int n = 0; n < 600; n++) begin
      we = {$urandom, $urandom};
      we[0] = ($urandom_range(0, 4) != 0);
      cyc(1'($urandom), pool[$urandom_range(0, 11)], 1'($urandom), we,
          $urandom_range(0, 40) == 0, $urandom_range(0, 8) == 0);
    end
    for (int k = 0; k < 4; k++) cyc(1, pool[k], 1, {$urandom, $urandom | 32'd1}, 0, 0);
    memcycle = 1;
    pgnoin = pool[0];
    tlbwr = 1;
    writeentry = 64'hDEAD_0000_0000_0001;
    #2;
    reset_n = 0;
    #1;
    chk("r_hit", 64'(hit), 64'd0);
    chk("r_pfn", 64'(pfnout), 64'd0);
    chk("r_flags", 64'(flagsout), 64'd0);
    chk("r_cnt", 64'(valid_cnt), 64'd0);
    mreset();
    tlbwr = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) look(pool[k]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
